// File: rtl/elevator_pkg.sv
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared types and constants for the elevator request dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int   FLOOR_W  = 6;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } disp_state_t;

  // Out-of-range floor reports are treated as the top served floor.
  function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] floor,
                                                     input int num_floors);
    if (int'(floor) >= num_floors) return FLOOR_W'(num_floors - 1);
    return floor;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_scan_select.sv
// ============================================================================
// Module   : elevator_scan_select
// Purpose  : Combinational SCAN-order pick of the next floor from a call mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_scan_select
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 48
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  input  logic                  i_dir_up,
  output logic                  o_found,
  output logic [FLOOR_W-1:0]    o_target,
  output logic                  o_new_dir
);

  logic [FLOOR_W-1:0] w_cf;
  logic               w_ge_lo_vld, w_gt_lo_vld, w_le_hi_vld, w_lt_hi_vld;
  logic [FLOOR_W-1:0] w_ge_lo, w_gt_lo, w_le_hi, w_lt_hi;

  assign w_cf = clamp_floor(i_current_floor, NUM_FLOORS);

  // Descending sweep leaves the lowest hit, ascending sweep the highest.
  always_comb begin
    w_ge_lo_vld = 1'b0;
    w_gt_lo_vld = 1'b0;
    w_le_hi_vld = 1'b0;
    w_lt_hi_vld = 1'b0;
    w_ge_lo     = '0;
    w_gt_lo     = '0;
    w_le_hi     = '0;
    w_lt_hi     = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (i_pending[f] && (f >= int'(w_cf))) begin
        w_ge_lo_vld = 1'b1;
        w_ge_lo     = FLOOR_W'(f);
      end
      if (i_pending[f] && (f > int'(w_cf))) begin
        w_gt_lo_vld = 1'b1;
        w_gt_lo     = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (i_pending[f] && (f <= int'(w_cf))) begin
        w_le_hi_vld = 1'b1;
        w_le_hi     = FLOOR_W'(f);
      end
      if (i_pending[f] && (f < int'(w_cf))) begin
        w_lt_hi_vld = 1'b1;
        w_lt_hi     = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    o_found   = 1'b0;
    o_target  = '0;
    o_new_dir = i_dir_up;
    if (i_dir_up) begin
      if (w_ge_lo_vld) begin
        o_found  = 1'b1;
        o_target = w_ge_lo;
      end else if (w_lt_hi_vld) begin
        o_found   = 1'b1;
        o_target  = w_lt_hi;
        o_new_dir = DIR_DOWN;
      end
    end else begin
      if (w_le_hi_vld) begin
        o_found  = 1'b1;
        o_target = w_le_hi;
      end else if (w_gt_lo_vld) begin
        o_found   = 1'b1;
        o_target  = w_gt_lo;
        o_new_dir = DIR_UP;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_request_dispatcher.sv
// ============================================================================
// Module   : elevator_request_dispatcher
// Purpose  : Latches floor calls, issues SCAN-ordered targets, times door dwell.
//            Optional en-route retargeting enabled by ELEVATOR_RETARGET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_request_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 48,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] i_btn_press,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_floor_request,
  output logic                  o_req_valid,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up
);

  localparam int               CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  disp_state_t           r_state, w_state_nxt;
  logic [FLOOR_W-1:0]    r_floor_request, w_floor_request_nxt;
  logic                  r_req_valid, w_req_valid_nxt;
  logic                  r_door_open, w_door_open_nxt;
  logic                  r_dir_up, w_dir_up_nxt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

  logic [NUM_FLOORS-1:0] w_fr_onehot, w_set, w_clr;
  logic                  w_sel_found, w_sel_dir;
  logic [FLOOR_W-1:0]    w_sel_target;
  logic                  w_retarget;
  logic [FLOOR_W-1:0]    w_retarget_floor;

  assign w_fr_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << r_floor_request;

  elevator_scan_select #(.NUM_FLOORS(NUM_FLOORS)) u_select (
    .i_pending       (r_pending),
    .i_current_floor (i_current_floor),
    .i_dir_up        (r_dir_up),
    .o_found         (w_sel_found),
    .o_target        (w_sel_target),
    .o_new_dir       (w_sel_dir)
  );

`ifdef ELEVATOR_RETARGET_EN
  logic [FLOOR_W-1:0]    w_cf;
  logic [NUM_FLOORS-1:0] w_rt_window, w_rt_pending;
  logic                  w_rt_found, w_rt_dir;
  logic [FLOOR_W-1:0]    w_rt_target;

  assign w_cf = clamp_floor(i_current_floor, NUM_FLOORS);

  // Only calls strictly between the car and its target, on the travel side.
  always_comb begin
    w_rt_window = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (r_dir_up) w_rt_window[f] = (f > int'(w_cf)) && (f < int'(r_floor_request));
      else          w_rt_window[f] = (f < int'(w_cf)) && (f > int'(r_floor_request));
    end
  end

  assign w_rt_pending = r_pending & w_rt_window;

  elevator_scan_select #(.NUM_FLOORS(NUM_FLOORS)) u_retarget (
    .i_pending       (w_rt_pending),
    .i_current_floor (i_current_floor),
    .i_dir_up        (r_dir_up),
    .o_found         (w_rt_found),
    .o_target        (w_rt_target),
    .o_new_dir       (w_rt_dir)
  );

  assign w_retarget       = w_rt_found && (w_rt_dir == r_dir_up);
  assign w_retarget_floor = w_rt_target;
`else
  assign w_retarget       = 1'b0;
  assign w_retarget_floor = r_floor_request;
`endif

  always_comb begin
    w_state_nxt         = r_state;
    w_floor_request_nxt = r_floor_request;
    w_req_valid_nxt     = r_req_valid;
    w_door_open_nxt     = r_door_open;
    w_dir_up_nxt        = r_dir_up;
    w_cnt_nxt           = r_cnt;
    w_set               = i_btn_press;
    w_clr               = '0;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_floor_request_nxt = w_sel_target;
          w_req_valid_nxt     = 1'b1;
          w_dir_up_nxt        = w_sel_dir;
          w_state_nxt         = SERVE;
        end
      end
      SERVE: begin
        if (i_current_floor == r_floor_request) begin
          w_state_nxt     = DWELL;
          w_door_open_nxt = 1'b1;
          w_cnt_nxt       = c_DWELL_LOAD;
        end else if (w_retarget) begin
          w_floor_request_nxt = w_retarget_floor;
        end
      end
      DWELL: begin
        // A press at the open floor holds the door instead of re-queueing.
        w_set = i_btn_press & ~w_fr_onehot;
        if (|(i_btn_press & w_fr_onehot)) begin
          w_cnt_nxt = c_DWELL_LOAD;
        end else if (r_cnt == '0) begin
          w_clr           = w_fr_onehot;
          w_door_open_nxt = 1'b0;
          w_req_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_floor_request <= '0;
      r_req_valid     <= 1'b0;
      r_door_open     <= 1'b0;
      r_dir_up        <= DIR_UP;
      r_pending       <= '0;
      r_cnt           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_floor_request <= w_floor_request_nxt;
      r_req_valid     <= w_req_valid_nxt;
      r_door_open     <= w_door_open_nxt;
      r_dir_up        <= w_dir_up_nxt;
      r_pending       <= w_pending_nxt;
      r_cnt           <= w_cnt_nxt;
    end
  end

  assign o_floor_request = r_floor_request;
  assign o_req_valid     = r_req_valid;
  assign o_door_open     = r_door_open;
  assign o_pending       = r_pending;
  assign o_dir_up        = r_dir_up;

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_dispatcher.sv
// ============================================================================
// Module   : tb_elevator_request_dispatcher
// Purpose  : Directed and randomized checks of the dispatcher against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_request_dispatcher;

  localparam int NF = 48;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] tb_btn;
  logic [5:0]    tb_cf;
  logic [5:0]    o_fr;
  logic          o_rv, o_door, o_dir;
  logic [NF-1:0] o_pend;

  int n_checks = 0;
  int n_pass   = 0;

  elevator_request_dispatcher #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_btn_press     (tb_btn),
    .i_current_floor (tb_cf),
    .o_floor_request (o_fr),
    .o_req_valid     (o_rv),
    .o_door_open     (o_door),
    .o_pending       (o_pend),
    .o_dir_up        (o_dir)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 waiting, 1 travelling, 2 door open.
  bit m_pend[NF];
  int m_tgt, m_phase, m_left;
  bit m_valid, m_door, m_dir;
  int mcf, mt, mclr, mign, mbest;
  bit mnd, many;

  function automatic void pick(input int cf, input bit dir, output int t, output bit nd);
    int calls[$];
    calls = {};
    for (int f = 0; f < NF; f++) if (m_pend[f]) calls.push_back(f);
    t  = -1;
    nd = dir;
    if (dir) begin
      foreach (calls[i]) if (t < 0 && calls[i] >= cf) t = calls[i];
      if (t < 0) begin
        foreach (calls[i]) if (calls[i] < cf) t = calls[i];
        nd = 1'b0;
      end
    end else begin
      foreach (calls[i]) if (calls[i] <= cf) t = calls[i];
      if (t < 0) begin
        foreach (calls[i]) if (t < 0 && calls[i] > cf) t = calls[i];
        nd = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
      m_tgt = 0; m_phase = 0; m_left = 0;
      m_valid = 1'b0; m_door = 1'b0; m_dir = 1'b1;
    end else begin
      mcf  = (int'(tb_cf) >= NF) ? NF - 1 : int'(tb_cf);
      mclr = -1;
      mign = -1;
      many = 1'b0;
      for (int f = 0; f < NF; f++) if (m_pend[f]) many = 1'b1;
      case (m_phase)
        0: if (many) begin
          pick(mcf, m_dir, mt, mnd);
          m_tgt = mt; m_dir = mnd; m_valid = 1'b1; m_phase = 1;
        end
        1: if (int'(tb_cf) == m_tgt) begin
          m_phase = 2; m_door = 1'b1; m_left = DW;
        end else begin
`ifdef ELEVATOR_RETARGET_EN
          mbest = -1;
          if (m_dir) begin
            for (int f = mcf + 1; f < m_tgt; f++) if (mbest < 0 && m_pend[f]) mbest = f;
          end else begin
            for (int f = mcf - 1; f > m_tgt; f--) if (mbest < 0 && m_pend[f]) mbest = f;
          end
          if (mbest >= 0) m_tgt = mbest;
`endif
        end
        default: begin
          mign = m_tgt;
          if (tb_btn[m_tgt]) m_left = DW;
          else if (m_left == 1) begin
            mclr = m_tgt; m_door = 1'b0; m_valid = 1'b0; m_phase = 0;
          end else m_left = m_left - 1;
        end
      endcase
      for (int f = 0; f < NF; f++) begin
        if (tb_btn[f] && f != mign) m_pend[f] = 1'b1;
        if (f == mclr) m_pend[f] = 1'b0;
      end
    end
  end

  logic [NF-1:0] exp_pend;
  always @(negedge clk) begin
    for (int f = 0; f < NF; f++) exp_pend[f] = m_pend[f];
    n_checks++;
    if (o_fr === 6'(m_tgt) && o_rv === m_valid && o_door === m_door &&
        o_dir === m_dir && o_pend === exp_pend) n_pass++;
    else
      $display("FAIL model_cmp t=%0t got fr=%0d rv=%0b door=%0b dir=%0b pend=%h want fr=%0d rv=%0b door=%0b dir=%0b pend=%h",
               $time, o_fr, o_rv, o_door, o_dir, o_pend, m_tgt, m_valid, m_door, m_dir, exp_pend);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (o_door === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  int n_open;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tb_btn = '0; tb_cf = 6'd0;
    repeat (3) tick();
    chk("reset_fr", 64'(o_fr), 64'd0);
    chk("reset_valid_door", {62'd0, o_rv, o_door}, 64'd0);
    chk("reset_pending", 64'(o_pend), 64'd0);
    chk("reset_dir", 64'(o_dir), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single call at floor 20 from floor 0
    tb_btn[20] = 1'b1; tick(); tb_btn = '0;
    chk("latch20_pending", 64'(o_pend[20]), 64'd1);
    chk("latch20_not_yet_valid", 64'(o_rv), 64'd0);
    tick();
    chk("t20_fr", 64'(o_fr), 64'd20);
    chk("t20_valid_dir", {62'd0, o_rv, o_dir}, 64'd3);
    tb_cf = 6'd20; tick();
    count_door(n_open);
    chk("t20_dwell_len", 64'(n_open), 64'd4);
    chk("t20_cleared", {63'd0, o_pend[20]}, 64'd0);
    chk("t20_valid_low", 64'(o_rv), 64'd0);

    // SCAN order: 15 ahead first, then reverse to 5
    tb_cf = 6'd10; tb_btn[5] = 1'b1; tb_btn[15] = 1'b1; tick(); tb_btn = '0;
    tick();
    chk("scan_first", 64'(o_fr), 64'd15);
    chk("scan_first_dir", 64'(o_dir), 64'd1);
    tb_cf = 6'd15; tick();
    count_door(n_open);
    tick();
    chk("scan_second", 64'(o_fr), 64'd5);
    chk("scan_reverse_dir", {62'd0, o_rv, o_dir}, 64'd2);
    tb_cf = 6'd5; tick();
    count_door(n_open);
    chk("scan_all_clear", 64'(o_pend), 64'd0);

    // Call at the floor the car is sitting on
    tb_cf = 6'd7; tb_btn[7] = 1'b1; tick(); tb_btn = '0;
    tick();
    chk("same_floor_serve", {56'd0, o_fr, o_rv, o_door}, {56'd0, 6'd7, 1'b1, 1'b0});
    tick();
    chk("same_floor_door", 64'(o_door), 64'd1);
    count_door(n_open);
    chk("same_floor_dwell_len", 64'(n_open), 64'd4);
    chk("same_floor_cleared", 64'(o_pend[7]), 64'd0);

    // Door hold by pressing the open floor on the 2nd dwell cycle
    tb_cf = 6'd12; tb_btn[12] = 1'b1; tick(); tb_btn = '0;
    tick(); tick();
    chk("hold_door_open", 64'(o_door), 64'd1);
    tick();
    tb_btn[12] = 1'b1; tick(); tb_btn = '0;
    count_door(n_open);
    chk("hold_dwell_len", 64'(n_open), 64'd4);
    chk("hold_not_relatched", 64'(o_pend[12]), 64'd0);

    // En-route call between car and target
    tb_cf = 6'd0; tb_btn[30] = 1'b1; tick(); tb_btn = '0;
    tick();
    chk("travel_fr30", 64'(o_fr), 64'd30);
    chk("travel_dir_up", 64'(o_dir), 64'd1);
    tb_cf = 6'd9; tb_btn[18] = 1'b1; tick(); tb_btn = '0;
    tick();
`ifdef ELEVATOR_RETARGET_EN
    chk("retarget_fr", 64'(o_fr), 64'd18);
`else
    chk("retarget_fr", 64'(o_fr), 64'd30);
`endif
    chk("retarget_keep30", 64'(o_pend[30]), 64'd1);

    // Asynchronous reset while serving
    rst_n = 1'b0; #3; rst_n = 1'b1;
    tb_cf = 6'd20; tb_btn[3] = 1'b1; tb_btn[40] = 1'b1; tick(); tb_btn = '0;
    tick();
    chk("pre_reset_fr", {57'd0, o_fr, o_rv}, {57'd0, 6'd40, 1'b1});
    #2; rst_n = 1'b0; #1;
    chk("async_rst_fr_rv_door", {56'd0, o_fr, o_rv, o_door}, 64'd0);
    chk("async_rst_pending", 64'(o_pend), 64'd0);
    chk("async_rst_dir", 64'(o_dir), 64'd1);
    tick(); tick();
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      tb_btn = '0;
      if ($urandom_range(0, 3) == 0) tb_btn[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) tb_btn[$urandom_range(0, NF - 1)] = 1'b1;
      if (m_phase == 2 && $urandom_range(0, 7) == 0) tb_btn[m_tgt] = 1'b1;
      if (m_phase == 1 && $urandom_range(0, 2) == 0) begin
        if (int'(tb_cf) < m_tgt) tb_cf = tb_cf + 6'd1;
        else if (int'(tb_cf) > m_tgt) tb_cf = tb_cf - 6'd1;
      end
      if ($urandom_range(0, 63) == 0) tb_cf = 6'($urandom_range(NF, 63));
      if ($urandom_range(0, 63) == 0) tb_cf = 6'($urandom_range(0, NF - 1));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; #2; rst_n = 1'b1;
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/elevator_request_dispatcher.md
Name: elevator_request_dispatcher

Overview:
- Request side of the Elevator_Control floor interface: latches car/hall button presses and drives floor_request to the controller.
- Watches current_floor for arrival, holds a door dwell, clears the served call, then issues the next target.
- Next-target selection uses SCAN order (continue in travel direction, reverse when nothing lies ahead).

Parameters:
NUM_FLOORS, 48, number of served floors (floors 0..NUM_FLOORS-1; legal range 2..64)
DWELL_CYCLES, 4, clock cycles the door stays open at a served floor (minimum 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
btn_press  input  NUM_FLOORS  one bit per floor; each high cycle registers a call
current_floor  input  6  floor reported by Elevator_Control
floor_request  output  6  target floor presented to Elevator_Control
req_valid  output  1  floor_request is an active, unserved target
door_open  output  1  high during dwell at the served floor
pending  output  NUM_FLOORS  latched outstanding calls
dir_up  output  1  current SCAN direction (1 = up)

Behaviour:
- Reset (reset=0, asynchronous): floor_request=0, req_valid=0, door_open=0, pending=0, dir_up=1, state IDLE, dwell counter=0.
- Latching: pending[f] sets on the edge where btn_press[f]=1 and is sticky until served. Duplicate presses have no effect.
- States are IDLE, SERVE and DWELL.
- IDLE with pending==0: outputs hold; floor_request keeps its last value.
- IDLE with pending!=0: selection is combinational. At the next edge, floor_request<=target, req_valid<=1, dir_up updated, state<=SERVE. Latency from a press edge to floor_request valid is 1 edge.
- Selection, dir_up=1: lowest pending floor >= current_floor. If there is none, set dir_up<=0 and pick the highest pending floor < current_floor.
- Selection, dir_up=0: mirror of the up rule (highest pending floor <= current_floor, else reverse and pick the lowest pending floor > current_floor).
- A call at current_floor always wins selection.
- SERVE: when current_floor==floor_request, the next edge moves to DWELL, sets door_open=1 and loads the counter with DWELL_CYCLES-1.
- DWELL: counter decrements each edge. On the edge where counter==0: pending[floor_request]<=0, door_open<=0, req_valid<=0, state<=IDLE.
- Same-floor press in DWELL: btn_press for floor_request reloads the counter (door held open). It is not re-latched.
- Same-floor press in SERVE: no special handling; the call is cleared on service.
- Simultaneous press of another floor and a clear: both take effect in the same edge.
- current_floor >= NUM_FLOORS: never matches, so no arrival. Selection treats it as NUM_FLOORS-1.
- Reset mid-operation: all calls are lost and outputs return to reset values immediately.
- btn_press bits change only pending. They never alter a target already in SERVE, except as described under Optional Feature.

Optional Feature:
ELEVATOR_RETARGET_EN
- Defined: in SERVE, a pending floor strictly between current_floor and floor_request, in the dir_up direction, replaces floor_request at the next edge. The nearest such floor is taken. The displaced target stays pending.
- Undefined: the target is fixed from selection until arrival.

Decomposition:
- Package elevator_pkg: FLOOR_W=6; enum disp_state_t {IDLE, SERVE, DWELL}; DIR_UP/DIR_DOWN constants.
- Sub-module elevator_scan_select: combinational. Inputs are pending, current_floor and dir_up. Outputs are found, target and new_dir. It is reused by the retarget path with a bounded search window.

Test Plan:
- Reset, then btn_press[20] pulse with current_floor=0 -> edge+1: floor_request=20, req_valid=1, dir_up=1. Drive current_floor=20 -> door_open high 4 cycles, then pending[20]=0, req_valid=0.
- current_floor=10, dir_up=1, presses 5 and 15 in the same cycle -> target 15 first. After service: dir_up=0, target 5.
- Press at current floor 7 while IDLE at 7 -> SERVE for 1 cycle, DWELL 4 cycles, then pending cleared.
- During DWELL at 12, press btn_press[12] on the 2nd dwell cycle -> door_open stays high 4 cycles after that press.
- With ELEVATOR_RETARGET_EN: travelling 0->30, press 18 while current_floor=9 -> floor_request=18 next edge, pending[30] retained. Without the macro -> floor_request stays 30.
- Assert reset mid-SERVE with pending={3,40} -> all outputs return to reset values asynchronously and pending=0.
